// File: rtl/vram_painter_pkg.sv
// Shared display definitions for the VRAM painter: colour type, panel geometry,
// VRAM addressing and the painter state encoding.
package vram_painter_pkg;

    typedef logic [15:0] ILI9341_color_t;

    localparam ILI9341_color_t BLACK = 16'h0000;
    localparam ILI9341_color_t RED   = 16'hF800;
    localparam ILI9341_color_t GREEN = 16'h07E0;
    localparam ILI9341_color_t BLUE  = 16'h001F;
    localparam ILI9341_color_t WHITE = 16'hFFFF;

    localparam int unsigned DISPLAY_WIDTH  = 240;
    localparam int unsigned DISPLAY_HEIGHT = 320;
    localparam int unsigned VRAM_DEPTH     = DISPLAY_WIDTH * DISPLAY_HEIGHT;
    localparam int unsigned VRAM_ADDR_W    = $clog2(VRAM_DEPTH);
    localparam int unsigned TOUCH_COORD_W  = 9;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_PAINT = 2'd2
    } painter_state_e;

endpackage

// File: rtl/vram_painter_if.sv
// Touch/clear inputs and VRAM write-port outputs of the painter.
// master: the painter itself; slave: touch controller / VRAM / monitor side.
interface vram_painter_if
    import vram_painter_pkg::*;
#(
    parameter int unsigned ADDR_W = VRAM_ADDR_W
);
    logic                     clear_req;
    logic                     touch_valid;
    logic [TOUCH_COORD_W-1:0] touch_x;
    logic [TOUCH_COORD_W-1:0] touch_y;
    ILI9341_color_t           color;

    logic                     vram_wr_ena;
    logic [ADDR_W-1:0]        vram_wr_addr;
    ILI9341_color_t           vram_wr_data;
    logic                     busy;
    logic                     clearing;

    modport master (
        input  clear_req, touch_valid, touch_x, touch_y, color,
        output vram_wr_ena, vram_wr_addr, vram_wr_data, busy, clearing
    );

    modport slave (
        output clear_req, touch_valid, touch_x, touch_y, color,
        input  vram_wr_ena, vram_wr_addr, vram_wr_data, busy, clearing
    );
endinterface

// File: rtl/vram_painter_brush_scanner.sv
// Walks the (2R+1)^2 brush offsets around a latched centre, dy outer / dx inner,
// and reports the clipped pixel for the current offset.
module vram_painter_brush_scanner
    import vram_painter_pkg::*;
#(
    parameter int unsigned DISPLAY_WIDTH  = vram_painter_pkg::DISPLAY_WIDTH,
    parameter int unsigned DISPLAY_HEIGHT = vram_painter_pkg::DISPLAY_HEIGHT,
    parameter int unsigned BRUSH_RADIUS   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     step_i,
    input  logic [TOUCH_COORD_W-1:0] cx_i,
    input  logic [TOUCH_COORD_W-1:0] cy_i,
    output logic [TOUCH_COORD_W-1:0] px_o,
    output logic [TOUCH_COORD_W-1:0] py_o,
    output logic                     in_bounds_o,
    output logic                     last_o
);
    localparam logic signed [10:0] R_S = 11'(BRUSH_RADIUS);
    localparam logic signed [10:0] W_S = 11'(DISPLAY_WIDTH);
    localparam logic signed [10:0] H_S = 11'(DISPLAY_HEIGHT);

    logic signed [10:0]       dx_q, dy_q;
    logic [TOUCH_COORD_W-1:0] cx_q, cy_q;
    logic signed [10:0]       px_s, py_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            dx_q <= -R_S;
            dy_q <= -R_S;
            cx_q <= '0;
            cy_q <= '0;
        end else if (start_i) begin
            dx_q <= -R_S;
            dy_q <= -R_S;
            cx_q <= cx_i;
            cy_q <= cy_i;
        end else if (step_i) begin
            if (dx_q == R_S) begin
                dx_q <= -R_S;
                dy_q <= dy_q + 11'sd1;
            end else begin
                dx_q <= dx_q + 11'sd1;
            end
        end
    end

    // Signed 11-bit sums so offsets left of column 0 / above row 0 go negative
    always_comb begin
        px_s        = $signed({2'b00, cx_q}) + dx_q;
        py_s        = $signed({2'b00, cy_q}) + dy_q;
        in_bounds_o = (px_s >= 11'sd0) && (px_s < W_S) && (py_s >= 11'sd0) && (py_s < H_S);
        last_o      = (dx_q == R_S) && (dy_q == R_S);
        px_o        = px_s[TOUCH_COORD_W-1:0];
        py_o        = py_s[TOUCH_COORD_W-1:0];
    end

endmodule

// File: rtl/vram_painter.sv
// VRAM write-port master: full-screen clear after reset / on request, then square
// brush painting at touch points. Optional macro VRAM_PAINTER_DEDUP_EN drops repeats.
module vram_painter
    import vram_painter_pkg::*;
#(
    parameter int unsigned    DISPLAY_WIDTH  = vram_painter_pkg::DISPLAY_WIDTH,
    parameter int unsigned    DISPLAY_HEIGHT = vram_painter_pkg::DISPLAY_HEIGHT,
    parameter int unsigned    BRUSH_RADIUS   = 2,
    parameter ILI9341_color_t CLEAR_COLOR    = BLACK
) (
    input logic          clk,
    input logic          rst,
    vram_painter_if.master bus
);
    localparam int unsigned VRAM_L = DISPLAY_WIDTH * DISPLAY_HEIGHT;
    localparam int unsigned ADDR_W = $clog2(VRAM_L);

    painter_state_e           state_q;
    logic [ADDR_W-1:0]        clr_cnt_q, clr_cnt_d;
    ILI9341_color_t           color_q;
    logic                     wr_ena_q;
    logic [ADDR_W-1:0]        wr_addr_q;
    ILI9341_color_t           wr_data_q;
    logic                     busy_q;
    logic                     clearing_q;

    logic                     touch_ok, dup, capture, step, clr_last;
    logic [TOUCH_COORD_W-1:0] px, py;
    logic                     in_bounds, last;
    logic [ADDR_W-1:0]        pix_addr;

    vram_painter_brush_scanner #(
        .DISPLAY_WIDTH (DISPLAY_WIDTH),
        .DISPLAY_HEIGHT(DISPLAY_HEIGHT),
        .BRUSH_RADIUS  (BRUSH_RADIUS)
    ) u_scanner (
        .clk        (clk),
        .rst        (rst),
        .start_i    (capture),
        .step_i     (step),
        .cx_i       (bus.touch_x),
        .cy_i       (bus.touch_y),
        .px_o       (px),
        .py_o       (py),
        .in_bounds_o(in_bounds),
        .last_o     (last)
    );

    always_comb begin
        touch_ok  = bus.touch_valid && (32'(bus.touch_x) < DISPLAY_WIDTH)
                                    && (32'(bus.touch_y) < DISPLAY_HEIGHT);
        capture   = (state_q == S_IDLE) && !bus.clear_req && touch_ok && !dup;
        step      = (state_q == S_PAINT) && !bus.clear_req;
        clr_cnt_d = clr_cnt_q + 1'b1;
        clr_last  = (clr_cnt_q == ADDR_W'(VRAM_L - 1));
        pix_addr  = ADDR_W'(py) * ADDR_W'(DISPLAY_WIDTH) + ADDR_W'(px);
    end

`ifdef VRAM_PAINTER_DEDUP_EN
    logic [TOUCH_COORD_W-1:0] last_x_q, last_y_q;
    ILI9341_color_t           last_color_q;
    logic                     last_valid_q;

    // Any clear or a lifted finger forgets the last point, so a re-touch repaints
    always_ff @(posedge clk) begin
        if (rst) begin
            last_valid_q <= 1'b0;
            last_x_q     <= '0;
            last_y_q     <= '0;
            last_color_q <= '0;
        end else if (state_q == S_CLEAR || bus.clear_req) begin
            last_valid_q <= 1'b0;
        end else if (state_q == S_IDLE) begin
            if (!bus.touch_valid) begin
                last_valid_q <= 1'b0;
            end else if (capture) begin
                last_valid_q <= 1'b1;
                last_x_q     <= bus.touch_x;
                last_y_q     <= bus.touch_y;
                last_color_q <= bus.color;
            end
        end
    end

    assign dup = last_valid_q && (bus.touch_x == last_x_q) && (bus.touch_y == last_y_q)
                 && (bus.color == last_color_q);
`else
    assign dup = 1'b0;
`endif

    // busy/clearing sample the pre-edge state so they stay aligned with the write they accompany
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_CLEAR;
            clr_cnt_q  <= '0;
            color_q    <= '0;
            wr_ena_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b1;
            clearing_q <= 1'b1;
        end else begin
            busy_q     <= (state_q != S_IDLE);
            clearing_q <= (state_q == S_CLEAR);
            wr_ena_q   <= 1'b0;
            unique case (state_q)
                S_CLEAR: begin
                    wr_ena_q  <= 1'b1;
                    wr_addr_q <= clr_cnt_q;
                    wr_data_q <= CLEAR_COLOR;
                    if (clr_last) begin
                        clr_cnt_q <= '0;
                        state_q   <= S_IDLE;
                    end else begin
                        clr_cnt_q <= clr_cnt_d;
                    end
                end
                S_IDLE: begin
                    if (bus.clear_req) begin
                        clr_cnt_q <= '0;
                        state_q   <= S_CLEAR;
                    end else if (capture) begin
                        color_q <= bus.color;
                        state_q <= S_PAINT;
                    end
                end
                S_PAINT: begin
                    if (bus.clear_req) begin
                        clr_cnt_q <= '0;
                        state_q   <= S_CLEAR;
                    end else begin
                        wr_ena_q <= in_bounds;
                        if (in_bounds) begin
                            wr_addr_q <= pix_addr;
                            wr_data_q <= color_q;
                        end
                        if (last) state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_CLEAR;
            endcase
        end
    end

    assign bus.vram_wr_ena  = wr_ena_q;
    assign bus.vram_wr_addr = wr_addr_q;
    assign bus.vram_wr_data = wr_data_q;
    assign bus.busy         = busy_q;
    assign bus.clearing     = clearing_q;

endmodule

// File: tb/tb_vram_painter.sv
// Bench for vram_painter on a 240x64 panel (row stride kept at 240): per-cycle
// comparison against a behavioural model plus directed literal checks.
module tb_vram_painter;
    localparam int W  = 240;
    localparam int H  = 64;
    localparam int R  = 2;
    localparam int L  = W * H;
    localparam int AW = $clog2(L);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vram_painter_if #(.ADDR_W(AW)) vif ();

    vram_painter #(
        .DISPLAY_WIDTH (W),
        .DISPLAY_HEIGHT(H),
        .BRUSH_RADIUS  (R),
        .CLEAR_COLOR   (16'h0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(vif)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { bit en; int unsigned addr; } pix_t;
    pix_t        pq[$];
    bit          model_ready = 0;
    bit          m_in_clear, m_in_paint;
    int unsigned m_idx;
    logic [15:0] m_col;
    bit          m_lastv;
    int          m_lx, m_ly;
    logic [15:0] m_lc;
    bit          e_en, e_busy, e_clr;
    int unsigned e_addr;
    logic [15:0] e_data;
    int unsigned mlog[$];

    function automatic bit model_dup(input int x, input int y, input logic [15:0] c);
`ifdef VRAM_PAINTER_DEDUP_EN
        return m_lastv && x == m_lx && y == m_ly && c == m_lc;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        int x, y;
        pix_t p;
        x = int'(vif.touch_x);
        y = int'(vif.touch_y);
        if (rst) begin
            model_ready = 1;
            e_en = 0; e_busy = 1; e_clr = 1;
            m_in_clear = 1; m_in_paint = 0; m_idx = 0; m_lastv = 0;
            pq.delete();
        end else begin
            e_busy = m_in_clear || m_in_paint;
            e_clr  = m_in_clear;
            e_en   = 0;
            if (m_in_clear) begin
                e_en = 1; e_addr = m_idx; e_data = 16'h0000;
                m_idx++;
                m_lastv = 0;
                if (m_idx == L) begin m_in_clear = 0; m_idx = 0; end
            end else if (vif.clear_req) begin
                m_in_paint = 0; m_in_clear = 1; m_idx = 0; m_lastv = 0;
                pq.delete();
            end else if (m_in_paint) begin
                p = pq.pop_front();
                e_en = p.en;
                if (p.en) begin e_addr = p.addr; e_data = m_col; end
                if (pq.size() == 0) m_in_paint = 0;
            end else if (vif.touch_valid && x < W && y < H && !model_dup(x, y, vif.color)) begin
                for (int dy = -R; dy <= R; dy++)
                    for (int dx = -R; dx <= R; dx++) begin
                        p.en   = (x + dx >= 0) && (x + dx < W) && (y + dy >= 0) && (y + dy < H);
                        p.addr = p.en ? int'(unsigned'((y + dy) * W + (x + dx))) : 0;
                        pq.push_back(p);
                    end
                m_in_paint = 1; m_col = vif.color;
                m_lastv = 1; m_lx = x; m_ly = y; m_lc = vif.color;
            end else if (!vif.touch_valid) begin
                m_lastv = 0;
            end
            if (e_en) mlog.push_back(e_addr);
        end
    end

    // ---------------- per-cycle compare ----------------
    int unsigned dlog[$];
    int          busy_cnt = 0;
    int          rise_cnt = 0;
    bit          prev_busy = 0;

    always @(negedge clk) begin
        if (model_ready) begin
            check("wr_ena", vif.vram_wr_ena, e_en);
            if (e_en) begin
                check("wr_addr", vif.vram_wr_addr, e_addr);
                check("wr_data", vif.vram_wr_data, e_data);
            end
            check("busy", vif.busy, e_busy);
            check("clearing", vif.clearing, e_clr);
            if (vif.vram_wr_ena === 1'b1) dlog.push_back(int'(vif.vram_wr_addr));
            if (vif.busy === 1'b1) busy_cnt++;
            if (vif.busy === 1'b1 && !prev_busy) rise_cnt++;
            prev_busy = (vif.busy === 1'b1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic start_log();
        dlog.delete(); mlog.delete(); busy_cnt = 0; rise_cnt = 0;
    endtask

    task automatic touch(input int x, input int y, input logic [15:0] c);
        vif.touch_valid = 1'b1; vif.touch_x = 9'(x); vif.touch_y = 9'(y); vif.color = c;
        tick(1);
        vif.touch_valid = 1'b0;
    endtask

    int unsigned exp00[9] = '{0, 1, 2, 240, 241, 242, 480, 481, 482};
    int          exp_paints;

    initial begin
        vif.clear_req = 1'b0; vif.touch_valid = 1'b0;
        vif.touch_x = '0; vif.touch_y = '0; vif.color = '0;
        tick(3);
        rst = 1'b0;
        tick(L + 5);
        check("clear count", dlog.size(), L);
        check("clear first", dlog[0], 0);
        check("clear last", dlog[dlog.size()-1], L - 1);
        check("busy idle", vif.busy, 0);

        start_log();
        touch(100, 50, 16'hF800);
        tick(30);
        check("c100 writes", dlog.size(), 25);
        check("c100 first", dlog[0], 11618);
        check("c100 last", dlog[24], 12582);
        check("c100 stride", dlog[5] - dlog[0], 240);
        check("c100 busy", busy_cnt, 25);
        check("model c100 first", mlog[0], 11618);
        check("model c100 last", mlog[24], 12582);

        start_log();
        touch(0, 0, 16'h07E0);
        tick(30);
        check("c00 writes", dlog.size(), 9);
        check("c00 busy", busy_cnt, 25);
        for (int i = 0; i < 9; i++) check("c00 addr", dlog[i], exp00[i]);

        start_log();
        touch(W - 1, H - 1, 16'h001F);
        tick(30);
        check("corner writes", dlog.size(), 9);
        check("corner last", dlog[8], L - 1);
        check("model corner last", mlog[8], L - 1);

        start_log();
        touch(250, 10, 16'hFFFF);
        touch(10, H, 16'hFFFF);
        tick(10);
        check("oob writes", dlog.size(), 0);
        check("oob busy", busy_cnt, 0);

        start_log();
        vif.touch_valid = 1'b1; vif.touch_x = 9'd10; vif.touch_y = 9'd10; vif.color = 16'hF800;
        tick(100);
        vif.touch_valid = 1'b0;
        tick(1);
        vif.touch_valid = 1'b1;
        tick(1);
        vif.touch_valid = 1'b0;
        tick(40);
`ifdef VRAM_PAINTER_DEDUP_EN
        exp_paints = 2;
`else
        exp_paints = 4;
`endif
        check("hold paints", rise_cnt, exp_paints);

        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                vif.touch_valid = ($urandom_range(0, 3) != 0);
                vif.touch_x     = 9'($urandom_range(0, 259));
                vif.touch_y     = 9'($urandom_range(0, 69));
                vif.color       = 16'($urandom);
            end
            tick(1);
        end
        vif.touch_valid = 1'b0;
        tick(30);

        start_log();
        touch(120, 30, 16'hF800);
        tick(9);
        vif.clear_req = 1'b1;
        tick(1);
        vif.clear_req = 1'b0;
        tick(9);
        check("abort writes", dlog.size(), 18);
        check("abort last paint", dlog[8], 7081);
        check("abort clear start", dlog[9], 0);
        tick(4992);
        check("mid clear addr", dlog[dlog.size()-1], 5000);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        start_log();
        tick(3);
        check("restart writes", dlog.size(), 3);
        check("restart addr", dlog[0], 0);
        tick(L + 5);

        start_log();
        vif.clear_req = 1'b1;
        vif.touch_valid = 1'b1; vif.touch_x = 9'd100; vif.touch_y = 9'd50; vif.color = 16'hF800;
        tick(1);
        vif.clear_req = 1'b0; vif.touch_valid = 1'b0;
        tick(4);
        check("clr+touch writes", dlog.size(), 4);
        check("clr+touch first", dlog[0], 0);
        check("clr+touch last", dlog[3], 3);
        tick(L + 5);
        check("final idle", vif.busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
